cordic_fix2float: RTL and testbench
===================================

Name: cordic_fix2float

Overview:
- Converts the signed fixed-point output of the CORDIC datapath back to IEEE-754 single precision.
- It is the inverse of the float-to-fixed front end: it takes the fixed-point result and produces the 32-bit float returned on `result`.
- Uses an iterative normaliser: one left shift per cycle, then round-to-nearest-even and pack.
- Uses a start/done handshake so the CORDIC control FSM can chain it after the final rotation.

Parameters:
- WIDTH, 32: width of the two's-complement fixed-point input.
- FRAC_BITS, 22: fractional bits of the input. Real value = fixedpoint × 2^-FRAC_BITS.
- Legal range: WIDTH ≥ 2; WIDTH-1-FRAC_BITS ≤ 127 and FRAC_BITS ≤ 126, so the output is never inf or denormal.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request. Sampled only in IDLE.
- fixedpoint  in  WIDTH  signed fixed-point operand. Captured on the edge that accepts start.
- busy  out  1  high from the accepting edge until the edge that raises done.
- done  out  1  single-cycle pulse; result is valid from this edge.
- result  out  32  IEEE-754 single. Held until the next done.

Behaviour:
- Reset (async, rst=1), any state: state=IDLE, busy=0, done=0, result=32'h0, internal shift counter=0. An in-flight conversion is abandoned with no done.
- States: IDLE, NORM, ROUND.
- IDLE, start=1 (accepting edge, call it edge 0):
  - sign ← fixedpoint[WIDTH-1].
  - mag ← |fixedpoint| as an unsigned WIDTH-bit value; the most negative input gives 2^(WIDTH-1) exactly.
  - cnt ← 0; busy ← 1; go to NORM.
- IDLE, start=0: hold state.
- NORM, each edge:
  - If mag==0: set zero flag and go to ROUND.
  - Else if mag[WIDTH-1]==1: go to ROUND.
  - Else: mag ← mag<<1, cnt ← cnt+1.
  - Shift count s = WIDTH-1-p, where p is the MSB index of the original magnitude.
- ROUND, one edge: result ← packed float; done ← 1; busy ← 0; go to IDLE. done drops on the next edge.
- Latency: done is high after edge s+2, for s = 0..WIDTH-1. Zero input gives done after edge 2.
- start asserted during busy, or on the done cycle, is ignored. The earliest next accept is the edge after the done edge.
- Packing:
  - exp = (WIDTH-1-cnt) - FRAC_BITS + 127.
  - Mantissa = mag[WIDTH-2 : WIDTH-24] (zero-padded below bit 0 if WIDTH < 25).
  - guard = next bit below the mantissa; sticky = OR of all remaining lower bits.
  - Round up if guard & (sticky | mantissa LSB).
  - If rounding carries out of 23 bits: mantissa=0, exp=exp+1.
  - Zero input gives +0 (32'h00000000), never -0.

Optional Feature:
- FIX2FLOAT_ONECYCLE_NORM_EN defined:
  - NORM is replaced by a priority encoder plus barrel shifter that completes in exactly one edge.
  - done is high after edge 2 for every input, including zero.
  - Results are bit-identical to the iterative form.
- Not defined: the iterative one-bit-per-cycle NORM with the data-dependent latency described above.

Test Plan (WIDTH=32, FRAC_BITS=22, macro undefined unless stated):
- Reset, then fixedpoint=32'h00400000 (1.0) with start → result=32'h3F800000, done after edge 11, busy high edges 0-10.
- 32'hFFC00000 (-1.0) → 32'hBF800000. 32'h80000000 → 32'hC4000000 (-512.0), done after edge 2.
- Zero input → result=32'h00000000 after edge 2. Then start held high through busy → exactly one done per accept, and the second operand is captured only after IDLE returns.
- Rounding:
  - 32'h7FFFFFFF → 32'h44000000 (round-up carry into exponent).
  - 32'h01000001 → 32'h40800000 (tie, stays even).
  - 32'h01000003 → 32'h40800002 (tie, rounds up).
- rst asserted asynchronously mid-NORM → busy, done and result go to 0 immediately and no done appears. A following 1.0 conversion is correct.
- With FIX2FLOAT_ONECYCLE_NORM_EN: repeat the first and fourth scenarios → same results, done after edge 2 in every case.

Source files
------------

// File: rtl/cordic_fix2float.sv
// Signed fixed-point to IEEE-754 single converter: normalise, round-to-nearest-even, pack.
// Define FIX2FLOAT_ONECYCLE_NORM_EN to replace the iterative normaliser with a one-edge barrel shift.
module cordic_fix2float #(
  parameter int WIDTH     = 32,
  parameter int FRAC_BITS = 22
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] fixedpoint,
  output logic             busy,
  output logic             done,
  output logic [31:0]      result
);

  localparam int CW       = $clog2(WIDTH) + 1;
  localparam int EXT      = (WIDTH < 26) ? 26 : WIDTH;
  localparam int EXP_BASE = WIDTH + 126 - FRAC_BITS;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    NORM  = 2'd1,
    ROUND = 2'd2
  } state_t;

  state_t            state_r, state_s;
  logic [WIDTH-1:0]  mag_r, mag_s;
  logic [CW-1:0]     cnt_r, cnt_s;
  logic              sign_r, sign_s;
  logic              zero_r, zero_s;
  logic              busy_r, busy_s;
  logic              done_r, done_s;
  logic [31:0]       result_r, result_s;

  // Fraction below the implicit one is left-aligned into EXT-1 bits so that
  // guard and sticky always exist, even for narrow inputs.
  function automatic logic [31:0] pack_float(
    input logic             s,
    input logic             z,
    input logic [WIDTH-2:0] frac_in,
    input logic [CW-1:0]    c
  );
    logic [EXT-2:0] frac;
    logic           rnd;
    logic [23:0]    mr;
    logic [7:0]     e;
    frac = (EXT-1)'(frac_in) << (EXT - WIDTH);
    rnd  = frac[EXT-25] & ((|frac[EXT-26:0]) | frac[EXT-24]);
    mr   = {1'b0, frac[EXT-2 -: 23]} + {23'd0, rnd};
    e    = 8'(EXP_BASE) - 8'(c) + {7'd0, mr[23]};
    return z ? 32'h0000_0000 : {s, e, mr[22:0]};
  endfunction

`ifdef FIX2FLOAT_ONECYCLE_NORM_EN
  function automatic logic [CW-1:0] lead_zeros(input logic [WIDTH-1:0] m);
    logic [CW-1:0] n;
    n = CW'(WIDTH - 1);
    for (int i = 0; i < WIDTH; i++) begin
      if (m[i]) begin
        n = CW'(WIDTH - 1 - i);
      end else begin
        n = n;
      end
    end
    return n;
  endfunction
`endif

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_s = NORM;
        end else begin
          state_s = IDLE;
        end
      end
      NORM: begin
`ifdef FIX2FLOAT_ONECYCLE_NORM_EN
        state_s = ROUND;
`else
        if ((mag_r == {WIDTH{1'b0}}) || mag_r[WIDTH-1]) begin
          state_s = ROUND;
        end else begin
          state_s = NORM;
        end
`endif
      end
      ROUND:   state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // Datapath and output next values
  always_comb begin
    mag_s    = mag_r;
    cnt_s    = cnt_r;
    sign_s   = sign_r;
    zero_s   = zero_r;
    busy_s   = busy_r;
    done_s   = 1'b0;
    result_s = result_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          sign_s = fixedpoint[WIDTH-1];
          mag_s  = fixedpoint[WIDTH-1] ? ({WIDTH{1'b0}} - fixedpoint) : fixedpoint;
          cnt_s  = {CW{1'b0}};
          zero_s = 1'b0;
          busy_s = 1'b1;
        end else begin
          busy_s = 1'b0;
        end
      end
      NORM: begin
`ifdef FIX2FLOAT_ONECYCLE_NORM_EN
        zero_s = (mag_r == {WIDTH{1'b0}});
        cnt_s  = lead_zeros(mag_r);
        mag_s  = mag_r << lead_zeros(mag_r);
`else
        if (mag_r == {WIDTH{1'b0}}) begin
          zero_s = 1'b1;
        end else if (mag_r[WIDTH-1]) begin
          zero_s = 1'b0;
        end else begin
          mag_s = mag_r << 1;
          cnt_s = cnt_r + CW'(1);
        end
`endif
      end
      ROUND: begin
        result_s = pack_float(sign_r, zero_r, mag_r[WIDTH-2:0], cnt_r);
        done_s   = 1'b1;
        busy_s   = 1'b0;
      end
      default: begin
        busy_s = 1'b0;
      end
    endcase
  end

  // Datapath and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mag_r    <= {WIDTH{1'b0}};
      cnt_r    <= {CW{1'b0}};
      sign_r   <= 1'b0;
      zero_r   <= 1'b0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      result_r <= 32'h0000_0000;
    end else begin
      mag_r    <= mag_s;
      cnt_r    <= cnt_s;
      sign_r   <= sign_s;
      zero_r   <= zero_s;
      busy_r   <= busy_s;
      done_r   <= done_s;
      result_r <= result_s;
    end
  end

  assign busy   = busy_r;
  assign done   = done_r;
  assign result = result_r;

endmodule

// File: tb/tb_cordic_fix2float.sv
// Randomised and directed bench for cordic_fix2float against a real-arithmetic reference model.
module tb_cordic_fix2float;

`ifdef FIX2FLOAT_ONECYCLE_NORM_EN
  localparam bit ONECYC = 1'b1;
`else
  localparam bit ONECYC = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [31:0] fixedpoint = 32'h0;
  logic        busy, done;
  logic [31:0] result;

  int errors = 0;
  int checks = 0;

  // model state
  int          rem_m  = 0;
  logic        busy_m = 1'b0;
  logic        done_m = 1'b0;
  logic [31:0] res_m  = 32'h0;
  logic [31:0] pend_m = 32'h0;

  cordic_fix2float #(.WIDTH(32), .FRAC_BITS(22)) dut (
    .clk(clk), .rst(rst), .start(start), .fixedpoint(fixedpoint),
    .busy(busy), .done(done), .result(result)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Value as a double is exact; round its 52-bit fraction to 23 bits (nearest even).
  function automatic logic [31:0] to_float(input logic [31:0] fp);
    real         v;
    logic [63:0] d;
    logic [31:0] f;
    int          e;
    if (fp == 32'h0) return 32'h0;
    v = $itor($signed(fp)) / 4194304.0;
    d = $realtobits(v);
    e = int'(d[62:52]) - 1023 + 127;
    f = {d[63], e[7:0], d[51:29]};
    if (d[28] && ((|d[27:0]) || d[29])) f = f + 32'd1;
    return f;
  endfunction

  function automatic int lat_of(input logic [31:0] fp);
    logic [31:0] m;
    int p;
    if (ONECYC) return 2;
    m = fp[31] ? (32'd0 - fp) : fp;
    if (m == 32'd0) return 2;
    p = 0;
    for (int i = 0; i < 32; i++) if (m[i]) p = i;
    return (31 - p) + 2;
  endfunction

  // Reference model: accept when idle, done after its latency
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      rem_m  <= 0;
      busy_m <= 1'b0;
      done_m <= 1'b0;
      res_m  <= 32'h0;
    end else begin
      done_m <= 1'b0;
      if (rem_m > 1) begin
        rem_m <= rem_m - 1;
      end else if (rem_m == 1) begin
        rem_m  <= 0;
        done_m <= 1'b1;
        busy_m <= 1'b0;
        res_m  <= pend_m;
      end else if (start) begin
        rem_m  <= lat_of(fixedpoint);
        pend_m <= to_float(fixedpoint);
        busy_m <= 1'b1;
      end
    end
  end

  // Cycle-by-cycle compare
  always @(negedge clk) begin
    chk("busy", {31'd0, busy}, {31'd0, busy_m});
    chk("done", {31'd0, done}, {31'd0, done_m});
    chk("result", result, res_m);
  end

  task automatic run_one(input logic [31:0] fp, input logic [31:0] exp_r,
                         input int exp_lat, input string nm);
    int n;
    start = 1'b1;
    fixedpoint = fp;
    @(posedge clk); #1;
    start = 1'b0;
    fixedpoint = $urandom;
    n = 0;
    while (!done && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk({nm, " latency"}, n, exp_lat);
    chk({nm, " value"}, result, exp_r);
    @(posedge clk); #1;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (rem_m != 0 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("idle timeout", {31'd0, n >= 100}, 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    logic [31:0] r;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("reset busy", {31'd0, busy}, 32'd0);
    chk("reset done", {31'd0, done}, 32'd0);
    chk("reset result", result, 32'h0);

    // pin the model to hand-computed values
    chk("model 1.0", to_float(32'h00400000), 32'h3F800000);
    chk("model -1.0", to_float(32'hFFC00000), 32'hBF800000);
    chk("model -512", to_float(32'h80000000), 32'hC4000000);
    chk("model carry", to_float(32'h7FFFFFFF), 32'h44000000);
    chk("model tie even", to_float(32'h01000001), 32'h40800000);
    chk("model tie up", to_float(32'h01000003), 32'h40800002);
    chk("model lat 1.0", lat_of(32'h00400000), ONECYC ? 32'd2 : 32'd11);

    run_one(32'h00400000, 32'h3F800000, ONECYC ? 2 : 11, "one");
    run_one(32'hFFC00000, 32'hBF800000, ONECYC ? 2 : 11, "minus one");
    run_one(32'h80000000, 32'hC4000000, 2, "most negative");
    run_one(32'h00000000, 32'h00000000, 2, "zero");
    run_one(32'h7FFFFFFF, 32'h44000000, ONECYC ? 2 : 3, "carry");
    run_one(32'h01000001, 32'h40800000, ONECYC ? 2 : 9, "tie even");
    run_one(32'h01000003, 32'h40800002, ONECYC ? 2 : 9, "tie up");

    // start held high with changing operand
    start = 1'b1;
    fixedpoint = 32'h0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      fixedpoint = $urandom >> $urandom_range(0, 31);
    end
    start = 1'b0;
    wait_idle();

    // random traffic, start toggling freely
    for (int i = 0; i < 3000; i++) begin
      r = $urandom >> $urandom_range(0, 31);
      if ($urandom_range(0, 1) == 1) r = 32'd0 - r;
      if ($urandom_range(0, 40) == 0) r = 32'h80000000;
      if ($urandom_range(0, 40) == 0) r = 32'h0;
      fixedpoint = r;
      start = ($urandom_range(0, 2) == 0);
      @(posedge clk); #1;
    end
    start = 1'b0;
    wait_idle();

    // asynchronous reset mid-conversion
    run_one(32'h00400000, 32'h3F800000, ONECYC ? 2 : 11, "pre reset");
    start = 1'b1;
    fixedpoint = 32'h00000001;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("async rst busy", {31'd0, busy}, 32'd0);
    chk("async rst done", {31'd0, done}, 32'd0);
    chk("async rst result", result, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    run_one(32'h00400000, 32'h3F800000, ONECYC ? 2 : 11, "post reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
